sram_bp_bank: RTL
=================

# sram_bp_bank

Parametrised single-port synchronous SRAM bank with a valid/ready request port, per-byte write strobes, an optional output register stage, and a hardware clear sequencer that zeroes the array after reset. It is the successor to the plain 8-bit SRAM and sits between the ARM7 core's load/store unit and on-chip memory. Read and write requests are accepted one per cycle once the clear sequence has finished.

## Interface
- ADDR_WIDTH, 10, word address bits; depth = 2**ADDR_WIDTH words.
- DATA_WIDTH, 32, word width; must be a multiple of 8; NBYTES = DATA_WIDTH/8.
- OUT_REG, 0, 0 gives read latency 1; 1 adds an output register stage, giving read latency 2.
- CLEAR_ON_RESET, 1, 1 runs the clear sequence after reset; 0 skips it, so array contents are undefined.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  bank can accept; a request transfers when req_valid && req_ready.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  DATA_WIDTH  write data.
- req_be  in  NBYTES  byte-lane write enables; bit i covers data[8i+7:8i].
- rsp_valid  out  1  one-cycle pulse carrying read data; only reads produce a response.
- rsp_rdata  out  DATA_WIDTH  read data; valid only while rsp_valid = 1.
- busy  out  1  clear sequence in progress.
- parity_err  out  NBYTES  per-lane parity error, aligned with rsp_valid (only with SRAM_PARITY_EN).
- inj_par  in  1  fault injection: invert stored parity on written lanes (only with SRAM_PARITY_EN).

## Operation
- State machine: CLEAR → RUN.
  - rst forces CLEAR (CLEAR_ON_RESET=1) or RUN (CLEAR_ON_RESET=0).
  - The clear counter resets to 0.
- CLEAR state:
  - Each cycle, write all-zero data (with correct parity) to address clear_cnt, then increment clear_cnt.
  - On clear_cnt == 2**ADDR_WIDTH-1, write that last word and move to RUN.
  - busy = 1 and req_ready = 0 throughout CLEAR.
- RUN state: req_ready = 1 and busy = 0.
- Write transfer: for each lane i with req_be[i] = 1, update that byte; other lanes keep their value. req_be = 0 is a legal no-op write.
- Read transfer: the array is read at the same edge. rsp_valid pulses after the read latency, with rsp_rdata equal to the word as it was before any write at that edge.
- Back-to-back: a write to address A at cycle n followed by a read of A at cycle n+1 returns the new data.
- No response backpressure: the consumer must accept rsp_valid whenever it pulses.
- Reset mid-operation:
  - Any in-flight read response is discarded: rsp_valid = 0, and the pipeline valid bits clear.
  - Array contents are not reset directly; they are re-zeroed by CLEAR when CLEAR_ON_RESET=1.
  - A reset during CLEAR restarts the sequence at address 0.

## Timing
- Reset values:
  - req_ready = 0 if CLEAR_ON_RESET=1, otherwise 1.
  - busy = CLEAR_ON_RESET.
  - rsp_valid = 0, rsp_rdata = 0, parity_err = 0.
- Clear duration: exactly 2**ADDR_WIDTH cycles from the first edge after rst deasserts. req_ready rises on the cycle after the last clear write.
- Read latency, measured from the accept edge:
  - OUT_REG=0: rsp_valid is high in the next cycle (latency 1).
  - OUT_REG=1: rsp_valid is high one cycle later (latency 2).
- Throughput: one request per cycle; consecutive reads yield consecutive rsp_valid pulses.
- Write-to-read visibility: 1 cycle.

## Configuration
- SRAM_PARITY_EN defined:
  - Each byte lane stores one extra even-parity bit, computed at write time. When inj_par = 1, the stored bit for each written lane is inverted.
  - On read, parity is recomputed per lane, and parity_err[i] is driven in the same cycle as rsp_valid; it is 0 otherwise.
  - The clear sequence writes correct parity.
- SRAM_PARITY_EN undefined:
  - No parity storage; the parity_err and inj_par ports are absent.
  - Array width = DATA_WIDTH.

## Test plan
- Clear: ADDR_WIDTH=4. Release rst → busy=1 for 16 cycles, then req_ready=1. A read of every address → rsp_rdata=0x00000000.
- Byte enables: write 0xAABBCCDD to addr 3 with be=0xF, then write 0x11223344 with be=0x5, then read → 0xAA22CC44.
- Latency:
  - OUT_REG=0: read accepted at edge n → rsp_valid high during cycle n+1.
  - OUT_REG=1: rsp_valid high during cycle n+2.
  - 4 back-to-back reads → 4 consecutive pulses in order.
- Write then read: write 0xDEADBEEF at addr 7 at cycle n, read addr 7 at cycle n+1 → 0xDEADBEEF.
- Reset mid-operation:
  - Assert rst while clear_cnt=9 → clear restarts at 0 and runs the full 16 cycles.
  - Assert rst with a read in flight → no rsp_valid pulse.
- Parity (SRAM_PARITY_EN): write 0x12345678 with be=0x2 and inj_par=1, then read → parity_err=0b0010 with rsp_valid. A clean write to the same address, then a read → parity_err=0.

Source files
------------

// File: rtl/sram_bp_bank.sv
// Single-port SRAM bank: valid/ready requests, byte strobes, optional output register, post-reset clear.
// Optional per-lane even parity storage is enabled by defining SRAM_PARITY_EN.
module sram_bp_bank #(
    parameter int ADDR_WIDTH     = 10,
    parameter int DATA_WIDTH     = 32,
    parameter int OUT_REG        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    input  logic [DATA_WIDTH/8-1:0]   req_be,
    output logic                      rsp_valid,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
`ifdef SRAM_PARITY_EN
    output logic [DATA_WIDTH/8-1:0]   parity_err,
    input  logic                      inj_par,
`endif
    output logic                      busy
);

    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int DEPTH  = 2 ** ADDR_WIDTH;

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;
    localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clear_cnt_q, clear_cnt_d;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  wr_en;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_dat;
    logic [NBYTES-1:0]     wr_be;

    logic                  rd_vld_q, rd_vld_d;
    logic [DATA_WIDTH-1:0] rd_dat_q, rd_dat_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RST_STATE;
            clear_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            clear_cnt_q <= clear_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        clear_cnt_d = clear_cnt_q;
        case (state_q)
            ST_CLEAR: begin
                clear_cnt_d = clear_cnt_q + 1'b1;
                if (clear_cnt_q == {ADDR_WIDTH{1'b1}}) state_d = ST_RUN;
            end
            default: ;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        req_ready = 1'b0;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        wr_addr   = req_addr;
        wr_dat    = req_wdata;
        wr_be     = req_be;
        case (state_q)
            ST_CLEAR: begin
                busy    = 1'b1;
                wr_en   = 1'b1;
                wr_addr = clear_cnt_q;
                wr_dat  = '0;
                wr_be   = '1;
            end
            default: begin
                req_ready = 1'b1;
                wr_en     = req_valid && req_write;
                rd_en     = req_valid && !req_write;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (wr_be[i]) mem_q[wr_addr][8*i +: 8] <= wr_dat[8*i +: 8];
            end
        end
    end

`ifdef SRAM_PARITY_EN
    logic [NBYTES-1:0] par_q [DEPTH];
    logic [NBYTES-1:0] rd_err_q, rd_err_d;
    logic              wr_inj;

    // Injection only applies to request writes; the clear always stores good parity.
    assign wr_inj = inj_par && (state_q == ST_RUN);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (wr_be[i]) par_q[wr_addr][i] <= (^wr_dat[8*i +: 8]) ^ wr_inj;
            end
        end
    end

    always_comb begin
        rd_err_d = '0;
        if (rd_en) begin
            for (int i = 0; i < NBYTES; i++) begin
                rd_err_d[i] = (^mem_q[req_addr][8*i +: 8]) ^ par_q[req_addr][i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_err_q <= '0;
        else     rd_err_q <= rd_err_d;
    end
`endif

    // Read samples the array before this edge's write lands, giving old data on a same-edge collision.
    always_comb begin
        rd_vld_d = rd_en;
        rd_dat_d = rd_en ? mem_q[req_addr] : rd_dat_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_vld_q <= 1'b0;
            rd_dat_q <= '0;
        end else begin
            rd_vld_q <= rd_vld_d;
            rd_dat_q <= rd_dat_d;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic                  out_vld_q, out_vld_d;
            logic [DATA_WIDTH-1:0] out_dat_q, out_dat_d;
`ifdef SRAM_PARITY_EN
            logic [NBYTES-1:0]     out_err_q, out_err_d;
            assign out_err_d  = rd_err_q;
            assign parity_err = out_err_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) out_err_q <= '0;
                else     out_err_q <= out_err_d;
            end
`endif
            always_comb begin
                out_vld_d = rd_vld_q;
                out_dat_d = rd_vld_q ? rd_dat_q : out_dat_q;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out_vld_q <= 1'b0;
                    out_dat_q <= '0;
                end else begin
                    out_vld_q <= out_vld_d;
                    out_dat_q <= out_dat_d;
                end
            end

            assign rsp_valid = out_vld_q;
            assign rsp_rdata = out_dat_q;
        end else begin : g_no_out_reg
            assign rsp_valid = rd_vld_q;
            assign rsp_rdata = rd_dat_q;
`ifdef SRAM_PARITY_EN
            assign parity_err = rd_err_q;
`endif
        end
    endgenerate

endmodule
